// File: rtl/image_converter_pkg.sv
// -----------------------------------------------------------------------------
// image_converter_pkg
// Shared definitions for the IMAGE_DATA_CONVERTER write-back path.
//   - default channel / raw-word widths
//   - channel slot indices inside an RGB pixel word ({R, G, B}, R in MSBs)
//   - half-word slot indices inside a raw word
//   - pair-packer FSM state encoding
// -----------------------------------------------------------------------------
package image_converter_pkg;

    localparam int RGB_W_DEF    = 8;
    localparam int RAW_W_DEF    = 2 * RGB_W_DEF;
    localparam int PIX_CHANNELS = 3;

    // Channel slot indices: a channel lives at [IDX*W +: W] of the pixel word
    localparam int PIX_R_IDX = 2;
    localparam int PIX_G_IDX = 1;
    localparam int PIX_B_IDX = 0;

    // Raw-word half slots: a half lives at [IDX*W +: W] of the raw word
    localparam int RAW_HI_IDX = 1;
    localparam int RAW_LO_IDX = 0;

    typedef enum logic {
        WAIT_P1 = 1'b0,
        HAVE_P1 = 1'b1
    } pack_state_t;

endpackage

// File: rtl/rgb_pair_pack.sv
// -----------------------------------------------------------------------------
// rgb_pair_pack
// Combinational packer: two RGB pixels -> two raw words.
//   data1 = {B, G2}, data2 = {G1, R}
//   CHROMA_MODE 0: R/B taken from the first pixel
//   CHROMA_MODE 1: R/B are floor averages of both pixels
// Ports:
//   p1, p2  in   first / second pixel of the pair, {R, G, B}
//   data1   out  packed word 1
//   data2   out  packed word 2
// -----------------------------------------------------------------------------
module rgb_pair_pack
    import image_converter_pkg::*;
#(
    parameter int DATA_WIDTH_RAW = RAW_W_DEF,
    parameter int DATA_WIDTH_RGB = RGB_W_DEF,
    parameter int CHROMA_MODE    = 0
) (
    input  logic [PIX_CHANNELS*DATA_WIDTH_RGB-1:0] p1,
    input  logic [PIX_CHANNELS*DATA_WIDTH_RGB-1:0] p2,
    output logic [DATA_WIDTH_RAW-1:0]              data1,
    output logic [DATA_WIDTH_RAW-1:0]              data2
);

    localparam int W = DATA_WIDTH_RGB;

    typedef logic [W-1:0] chan_t;

    // Sum kept one bit wider so the carry survives; dropping the LSB is the floor
    function automatic chan_t avg_floor(input chan_t a, input chan_t b);
        logic [W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[W:1];
    endfunction

    chan_t r1, g1, b1;
    chan_t r2, g2, b2;
    chan_t r_avg, b_avg;
    chan_t r_out, b_out;

    always_comb begin
        r1 = p1[PIX_R_IDX*W +: W];
        g1 = p1[PIX_G_IDX*W +: W];
        b1 = p1[PIX_B_IDX*W +: W];
        r2 = p2[PIX_R_IDX*W +: W];
        g2 = p2[PIX_G_IDX*W +: W];
        b2 = p2[PIX_B_IDX*W +: W];

        r_avg = avg_floor(r1, r2);
        b_avg = avg_floor(b1, b2);

        r_out = (CHROMA_MODE == 1) ? r_avg : r1;
        b_out = (CHROMA_MODE == 1) ? b_avg : b1;

        data1 = '0;
        data2 = '0;
        data1[RAW_HI_IDX*W +: W] = b_out;
        data1[RAW_LO_IDX*W +: W] = g2;
        data2[RAW_HI_IDX*W +: W] = g1;
        data2[RAW_LO_IDX*W +: W] = r_out;
    end

endmodule

// File: rtl/rgb2raw_packer.sv
// -----------------------------------------------------------------------------
// rgb2raw_packer
// Pairs consecutive RGB pixels and emits each pair as two raw words
// (shared chroma, per-pixel green). A line ending on an unpaired pixel is
// padded by duplicating that pixel and flagged with a one-cycle ODD_LINE.
// Ports:
//   ACLK, ARESETN       clock (rising edge), async active-low reset
//   S_TDATA/S_TVALID/   pixel stream in, {R, G, B}, S_TLAST marks line end
//   S_TREADY/S_TLAST
//   M_DATA1, M_DATA2    packed words {B, G2} and {G1, R}
//   M_TVALID/M_TREADY/  pair stream out, M_TLAST marks the pair closing a line
//   M_TLAST
//   ODD_LINE            pulse: line ended on a padded, unpaired pixel
// -----------------------------------------------------------------------------
module rgb2raw_packer
    import image_converter_pkg::*;
#(
    parameter int DATA_WIDTH_RAW = RAW_W_DEF,
    parameter int DATA_WIDTH_RGB = RGB_W_DEF,
    parameter int CHROMA_MODE    = 0
) (
    input  logic                                   ACLK,
    input  logic                                   ARESETN,
    input  logic [PIX_CHANNELS*DATA_WIDTH_RGB-1:0] S_TDATA,
    input  logic                                   S_TVALID,
    output logic                                   S_TREADY,
    input  logic                                   S_TLAST,
    output logic [DATA_WIDTH_RAW-1:0]              M_DATA1,
    output logic [DATA_WIDTH_RAW-1:0]              M_DATA2,
    output logic                                   M_TVALID,
    input  logic                                   M_TREADY,
    output logic                                   M_TLAST,
    output logic                                   ODD_LINE
);

    localparam int PIX_W = PIX_CHANNELS * DATA_WIDTH_RGB;

    generate
        if (DATA_WIDTH_RAW != 2 * DATA_WIDTH_RGB) begin : g_width_check
            $error("rgb2raw_packer: DATA_WIDTH_RAW must equal 2*DATA_WIDTH_RGB");
        end
    endgenerate

    pack_state_t             state, state_next;
    logic [PIX_W-1:0]        p1_q;
    logic [PIX_W-1:0]        pack_p1;
    logic [DATA_WIDTH_RAW-1:0] pack_d1, pack_d2;
    logic                    out_free;
    logic                    in_beat;
    logic                    load;

    // Ready depends only on the registered output stage, never on S_TVALID
    assign out_free = ~M_TVALID | M_TREADY;
    assign S_TREADY = out_free;
    assign in_beat  = S_TVALID & out_free;

    // In WAIT_P1 a load only happens for a padded line end, where the
    // incoming pixel is both halves of the pair.
    assign pack_p1 = (state == HAVE_P1) ? p1_q : S_TDATA;

    rgb_pair_pack #(
        .DATA_WIDTH_RAW (DATA_WIDTH_RAW),
        .DATA_WIDTH_RGB (DATA_WIDTH_RGB),
        .CHROMA_MODE    (CHROMA_MODE)
    ) u_pack (
        .p1    (pack_p1),
        .p2    (S_TDATA),
        .data1 (pack_d1),
        .data2 (pack_d2)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= WAIT_P1;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            WAIT_P1: begin
                if (in_beat) begin
                    if (S_TLAST) begin
                        load = 1'b1;
                    end else begin
                        state_next = HAVE_P1;
                    end
                end
            end
            HAVE_P1: begin
                if (in_beat) begin
                    load       = 1'b1;
                    state_next = WAIT_P1;
                end
            end
            default: state_next = WAIT_P1;
        endcase
    end

    // Held first pixel of the pair
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            p1_q <= '0;
        end else if (in_beat && (state == WAIT_P1) && !S_TLAST) begin
            p1_q <= S_TDATA;
        end
    end

    // Output register: a load in the same cycle as a drain replaces the pair
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            M_DATA1  <= '0;
            M_DATA2  <= '0;
            M_TVALID <= 1'b0;
            M_TLAST  <= 1'b0;
            ODD_LINE <= 1'b0;
        end else begin
            ODD_LINE <= in_beat && (state == WAIT_P1) && S_TLAST;
            if (load) begin
                M_DATA1  <= pack_d1;
                M_DATA2  <= pack_d2;
                M_TVALID <= 1'b1;
                M_TLAST  <= S_TLAST;
            end else if (M_TREADY) begin
                M_TVALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rgb2raw_packer.sv
module tb_rgb2raw_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        m_tready;

    logic        s_tready0, m_tvalid0, m_tlast0, odd_line0;
    logic [15:0] m_data1_0, m_data2_0;
    logic        s_tready1, m_tvalid1, m_tlast1, odd_line1;
    logic [15:0] m_data1_1, m_data2_1;

    int total = 0;
    int bad   = 0;

    logic [24:0] sent_q[$];   // {last, pixel} accepted by the DUTs
    logic [32:0] out0_q[$];   // {tlast, data1, data2} observed, mode 0
    logic [32:0] out1_q[$];   // same, mode 1
    logic [32:0] exp_q[$];
    int          odd0, odd1, exp_odd;

    always #5 clk = ~clk;

    rgb2raw_packer #(.DATA_WIDTH_RAW(16), .DATA_WIDTH_RGB(8), .CHROMA_MODE(0)) dut0 (
        .ACLK(clk), .ARESETN(rst_n), .S_TDATA(s_tdata), .S_TVALID(s_tvalid),
        .S_TREADY(s_tready0), .S_TLAST(s_tlast), .M_DATA1(m_data1_0), .M_DATA2(m_data2_0),
        .M_TVALID(m_tvalid0), .M_TREADY(m_tready), .M_TLAST(m_tlast0), .ODD_LINE(odd_line0)
    );

    rgb2raw_packer #(.DATA_WIDTH_RAW(16), .DATA_WIDTH_RGB(8), .CHROMA_MODE(1)) dut1 (
        .ACLK(clk), .ARESETN(rst_n), .S_TDATA(s_tdata), .S_TVALID(s_tvalid),
        .S_TREADY(s_tready1), .S_TLAST(s_tlast), .M_DATA1(m_data1_1), .M_DATA2(m_data2_1),
        .M_TVALID(m_tvalid1), .M_TREADY(m_tready), .M_TLAST(m_tlast1), .ODD_LINE(odd_line1)
    );

    // Output beat collection, away from the rising edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_tvalid0 && m_tready) out0_q.push_back({m_tlast0, m_data1_0, m_data2_0});
            if (m_tvalid1 && m_tready) out1_q.push_back({m_tlast1, m_data1_1, m_data2_1});
            if (odd_line0) odd0++;
            if (odd_line1) odd1++;
        end
    end

    // Reference pair packing from channel arithmetic
    function automatic logic [31:0] model_pack(input logic [23:0] a, input logic [23:0] b,
                                               input int mode);
        int r, bl;
        if (mode == 1) begin
            r  = (int'(a[23:16]) + int'(b[23:16])) / 2;
            bl = (int'(a[7:0]) + int'(b[7:0])) / 2;
        end else begin
            r  = int'(a[23:16]);
            bl = int'(a[7:0]);
        end
        return {bl[7:0], b[15:8], a[15:8], r[7:0]};
    endfunction

    // Expected beats from the accepted pixel sequence and the pairing rules
    task automatic build_expected(input int mode);
        logic [23:0] p1;
        logic        held;
        exp_q.delete();
        exp_odd = 0;
        held    = 1'b0;
        p1      = '0;
        foreach (sent_q[i]) begin
            if (!held) begin
                if (sent_q[i][24]) begin
                    exp_q.push_back({1'b1, model_pack(sent_q[i][23:0], sent_q[i][23:0], mode)});
                    exp_odd++;
                end else begin
                    p1   = sent_q[i][23:0];
                    held = 1'b1;
                end
            end else begin
                exp_q.push_back({sent_q[i][24], model_pack(p1, sent_q[i][23:0], mode)});
                held = 1'b0;
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        sent_q.delete();
        out0_q.delete();
        out1_q.delete();
        odd0 = 0;
        odd1 = 0;
    endtask

    // Offers one pixel; returns at edge+1 after acceptance
    task automatic send_pixel(input logic [23:0] d, input logic l, output int waits);
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        waits    = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (s_tready0) begin
                @(posedge clk);
                #1;
                s_tvalid = 1'b0;
                sent_q.push_back({l, d});
                return;
            end
            waits++;
        end
        bad++;
        $display("FAIL send_timeout got=no_accept exp=accept within 200 cycles");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "input never accepted");
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
        m_tready = 1'b1;
        step(3);
        total++;
        if ({m_tvalid0, m_tlast0, odd_line0} !== 3'b000) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=000", {m_tvalid0, m_tlast0, odd_line0});
        end
        total++;
        if ({m_data1_0, m_data2_0} !== 32'h0) begin
            bad++; $display("FAIL reset_data0 got=%h exp=0", {m_data1_0, m_data2_0});
        end
        total++;
        if ({m_data1_1, m_data2_1, m_tvalid1} !== 33'h0) begin
            bad++; $display("FAIL reset_data1 got=%h exp=0", {m_data1_1, m_data2_1, m_tvalid1});
        end
        rst_n = 1'b1;
        step(1);
        total++;
        if (s_tready0 !== 1'b1) begin
            bad++; $display("FAIL reset_ready got=%b exp=1", s_tready0);
        end
    endtask

    task automatic test_mode0();
        int w;
        clear_logs();
        m_tready = 1'b1;
        send_pixel(24'h112233, 1'b0, w);
        total++;
        if (m_tvalid0 !== 1'b0) begin
            bad++; $display("FAIL mode0_early got=%b exp=0", m_tvalid0);
        end
        send_pixel(24'h445566, 1'b0, w);
        total++;
        if ({m_tvalid0, m_tlast0, m_data1_0, m_data2_0} !== {2'b10, 16'h3355, 16'h2211}) begin
            bad++; $display("FAIL mode0_beat got=%b/%b/%h/%h exp=1/0/3355/2211",
                            m_tvalid0, m_tlast0, m_data1_0, m_data2_0);
        end
        step(1);
        total++;
        if (m_tvalid0 !== 1'b0) begin
            bad++; $display("FAIL mode0_drain got=%b exp=0", m_tvalid0);
        end
        step(2);
        total++;
        if (out0_q.size() !== 1) begin
            bad++; $display("FAIL mode0_count got=%0d exp=1", out0_q.size());
        end
    endtask

    task automatic test_mode1();
        int w;
        clear_logs();
        m_tready = 1'b1;
        send_pixel(24'h10F020, 1'b0, w);
        send_pixel(24'h30A0FF, 1'b0, w);
        total++;
        if ({m_tvalid1, m_data1_1, m_data2_1} !== {1'b1, 16'h8FA0, 16'hF020}) begin
            bad++; $display("FAIL mode1_avg got=%b/%h/%h exp=1/8fa0/f020",
                            m_tvalid1, m_data1_1, m_data2_1);
        end
        total++;
        if ({m_data1_0, m_data2_0} !== {16'h20A0, 16'hF010}) begin
            bad++; $display("FAIL mode1_first got=%h/%h exp=20a0/f010", m_data1_0, m_data2_0);
        end
        step(2);
    endtask

    task automatic test_odd_line();
        int w;
        clear_logs();
        m_tready = 1'b1;
        send_pixel(24'h010203, 1'b0, w);
        send_pixel(24'h040506, 1'b0, w);
        send_pixel(24'hAABBCC, 1'b1, w);
        total++;
        if ({m_tvalid0, m_tlast0, odd_line0, m_data1_0, m_data2_0} !==
            {3'b111, 16'hCCBB, 16'hBBAA}) begin
            bad++; $display("FAIL odd_beat got=%b%b%b/%h/%h exp=111/ccbb/bbaa",
                            m_tvalid0, m_tlast0, odd_line0, m_data1_0, m_data2_0);
        end
        step(1);
        total++;
        if (odd_line0 !== 1'b0) begin
            bad++; $display("FAIL odd_pulse_width got=%b exp=0", odd_line0);
        end
        step(2);
        build_expected(0);
        total++;
        if (odd0 !== exp_odd) begin
            bad++; $display("FAIL odd_count got=%0d exp=%0d", odd0, exp_odd);
        end
        total++;
        if (out0_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL odd_beats got=%0d exp=%0d", out0_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                total++;
                if (out0_q[i] !== exp_q[i]) begin
                    bad++; $display("FAIL odd_beat%0d got=%h exp=%h", i, out0_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [33:0] prev_out;
        logic        prev_stall;
        clear_logs();
        prev_out   = '0;
        prev_stall = 1'b0;
        fork
            begin
                int w;
                for (int i = 0; i < 8; i++) send_pixel(24'($urandom), 1'b0, w);
            end
            begin
                for (int c = 0; c < 60; c++) begin
                    m_tready = ((c % 4) == 0) || ((c % 4) == 3);
                    @(negedge clk);
                    total++;
                    if (s_tready0 !== (~m_tvalid0 | m_tready)) begin
                        bad++; $display("FAIL bp_ready c=%0d got=%b exp=%b", c, s_tready0,
                                        ~m_tvalid0 | m_tready);
                    end
                    if (prev_stall) begin
                        total++;
                        if ({m_tvalid0, m_tlast0, m_data1_0, m_data2_0} !== prev_out) begin
                            bad++; $display("FAIL bp_stable c=%0d got=%h exp=%h", c,
                                            {m_tvalid0, m_tlast0, m_data1_0, m_data2_0}, prev_out);
                        end
                    end
                    prev_out   = {m_tvalid0, m_tlast0, m_data1_0, m_data2_0};
                    prev_stall = m_tvalid0 && !m_tready;
                    @(posedge clk);
                    #1;
                end
            end
        join
        m_tready = 1'b1;
        step(3);
        build_expected(0);
        total++;
        if (out0_q.size() !== 4) begin
            bad++; $display("FAIL bp_count got=%0d exp=4", out0_q.size());
        end else begin
            foreach (exp_q[i]) begin
                total++;
                if (out0_q[i] !== exp_q[i]) begin
                    bad++; $display("FAIL bp_beat%0d got=%h exp=%h", i, out0_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int w, waits_total;
        clear_logs();
        m_tready    = 1'b1;
        waits_total = 0;
        for (int i = 0; i < 64; i++) begin
            send_pixel(24'($urandom), (i == 63), w);
            waits_total += w;
        end
        step(3);
        total++;
        if (waits_total !== 0) begin
            bad++; $display("FAIL b2b_stall got=%0d exp=0", waits_total);
        end
        build_expected(0);
        total++;
        if (out0_q.size() !== 32) begin
            bad++; $display("FAIL b2b_count got=%0d exp=32", out0_q.size());
        end else begin
            foreach (exp_q[i]) begin
                total++;
                if (out0_q[i] !== exp_q[i]) begin
                    bad++; $display("FAIL b2b_beat%0d got=%h exp=%h", i, out0_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int w;
        logic [23:0] pd, pe;
        clear_logs();
        m_tready = 1'b0;
        send_pixel(24'h123456, 1'b0, w);
        send_pixel(24'h789ABC, 1'b0, w);
        step(1);
        rst_n = 1'b0;
        #1;
        total++;
        if ({m_tvalid0, m_tlast0, odd_line0, m_data1_0, m_data2_0} !== 35'h0) begin
            bad++; $display("FAIL rstmid_outputs got=%b/%h/%h exp=0/0/0",
                            m_tvalid0, m_data1_0, m_data2_0);
        end
        step(2);
        rst_n    = 1'b1;
        m_tready = 1'b1;
        step(1);
        send_pixel(24'hDEAD01, 1'b0, w);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(1);
        clear_logs();
        pd = 24'($urandom);
        pe = 24'($urandom);
        send_pixel(pd, 1'b0, w);
        send_pixel(pe, 1'b0, w);
        step(3);
        total++;
        if (out0_q.size() !== 1) begin
            bad++; $display("FAIL rstmid_count got=%0d exp=1", out0_q.size());
        end else begin
            total++;
            if (out0_q[0] !== {1'b0, model_pack(pd, pe, 0)}) begin
                bad++; $display("FAIL rstmid_pair got=%h exp=%h", out0_q[0],
                                {1'b0, model_pack(pd, pe, 0)});
            end
        end
    endtask

    task automatic test_random();
        logic done;
        clear_logs();
        done = 1'b0;
        fork
            begin
                int w;
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) step($urandom_range(1, 2));
                    send_pixel(24'($urandom), ($urandom_range(0, 7) == 0), w);
                end
                done = 1'b1;
            end
            begin
                for (int c = 0; c < 20000 && !done; c++) begin
                    m_tready = ($urandom_range(0, 3) != 0);
                    step(1);
                end
            end
        join
        m_tready = 1'b1;
        step(4);
        build_expected(0);
        total++;
        if (odd0 !== exp_odd) begin
            bad++; $display("FAIL rand_odd0 got=%0d exp=%0d", odd0, exp_odd);
        end
        total++;
        if (out0_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL rand0_count got=%0d exp=%0d", out0_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                total++;
                if (out0_q[i] !== exp_q[i]) begin
                    bad++; $display("FAIL rand0_beat%0d got=%h exp=%h", i, out0_q[i], exp_q[i]);
                end
            end
        end
        build_expected(1);
        total++;
        if (odd1 !== exp_odd) begin
            bad++; $display("FAIL rand_odd1 got=%0d exp=%0d", odd1, exp_odd);
        end
        total++;
        if (out1_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL rand1_count got=%0d exp=%0d", out1_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                total++;
                if (out1_q[i] !== exp_q[i]) begin
                    bad++; $display("FAIL rand1_beat%0d got=%h exp=%h", i, out1_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode1();
        test_odd_line();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
